// File: rtl/conway_pkg.sv
// Shared types and helpers for the Conway 3x3 window generator.
// Holds the scan FSM state encoding, neighbour bit positions and the cell index helper.
// Everything here is compile-time only; no logic is generated by the package itself.
package conway_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit positions inside neighbor_values, named by compass direction.
    // North is row y-1, west is column x-1.
    localparam int NB_NW = 0;
    localparam int NB_N  = 1;
    localparam int NB_NE = 2;
    localparam int NB_W  = 3;
    localparam int NB_E  = 4;
    localparam int NB_SW = 5;
    localparam int NB_S  = 6;
    localparam int NB_SE = 7;

    // Flat bit index of cell (x,y) in a row-major board.
    function automatic int cell_idx(input int x, input int y, input int width);
        return y * width + x;
    endfunction

endpackage

// File: rtl/conway_cell_fetch.sv
// Combinational 3x3 window fetch: centre bit plus 8 neighbours of (i_x,i_y).
// Latency: zero cycles (pure combinational).
// Backpressure: none; the outputs follow the snapshot and coordinate inputs.
// Ports: i_snap board snapshot, i_x/i_y window coordinate,
//        o_center cell value, o_neighbors 8 neighbour bits.
// Macro CONWAY_WRAP_EN: defined gives a toroidal board, undefined gives a dead border.
module conway_cell_fetch
    import conway_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int HEIGHT = 16
) (
    input  logic [WIDTH*HEIGHT-1:0]   i_snap,
    input  logic [$clog2(WIDTH)-1:0]  i_x,
    input  logic [$clog2(HEIGHT)-1:0] i_y,
    output logic                      o_center,
    output logic [7:0]                o_neighbors
);

    localparam int N  = WIDTH * HEIGHT;
    localparam int IW = $clog2(N);

    // Read one cell at a signed coordinate that may lie one step off the board.
    function automatic logic cell_at(input logic [N-1:0] snap, input int cx, input int cy);
        logic [IW-1:0] idx;
`ifdef CONWAY_WRAP_EN
        // Off-board coordinates are at most one step out, so a compare is enough.
        if (cx < 0)            cx = WIDTH - 1;
        else if (cx >= WIDTH)  cx = 0;
        if (cy < 0)            cy = HEIGHT - 1;
        else if (cy >= HEIGHT) cy = 0;
        idx     = IW'(cell_idx(cx, cy, WIDTH));
        cell_at = snap[idx];
`else
        if (cx < 0 || cx >= WIDTH || cy < 0 || cy >= HEIGHT) begin
            idx     = '0;
            cell_at = 1'b0;
        end else begin
            idx     = IW'(cell_idx(cx, cy, WIDTH));
            cell_at = snap[idx];
        end
`endif
    endfunction

    int w_cx;
    int w_cy;

    assign w_cx = int'(i_x);
    assign w_cy = int'(i_y);

    always_comb begin
        o_neighbors         = '0;
        o_center            = cell_at(i_snap, w_cx,     w_cy);
        o_neighbors[NB_NW]  = cell_at(i_snap, w_cx - 1, w_cy - 1);
        o_neighbors[NB_N]   = cell_at(i_snap, w_cx,     w_cy - 1);
        o_neighbors[NB_NE]  = cell_at(i_snap, w_cx + 1, w_cy - 1);
        o_neighbors[NB_W]   = cell_at(i_snap, w_cx - 1, w_cy);
        o_neighbors[NB_E]   = cell_at(i_snap, w_cx + 1, w_cy);
        o_neighbors[NB_SW]  = cell_at(i_snap, w_cx - 1, w_cy + 1);
        o_neighbors[NB_S]   = cell_at(i_snap, w_cx,     w_cy + 1);
        o_neighbors[NB_SE]  = cell_at(i_snap, w_cx + 1, w_cy + 1);
    end

endmodule

// File: rtl/conway_window_gen.sv
// Snapshots a board on start and emits one 3x3 window per cell in raster order.
// Latency: first window valid the cycle after start; one window per accepted handshake.
// Backpressure: win_ready low holds win_valid and all window outputs stable.
// Ports: clk/rst (async active-high), start, board_in, win_valid/win_ready handshake,
//        center_value, neighbor_values, win_x, win_y, win_last, busy, done.
// Macro CONWAY_WRAP_EN (in conway_cell_fetch): toroidal edges when defined.
module conway_window_gen
    import conway_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int HEIGHT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [WIDTH*HEIGHT-1:0]   board_in,
    output logic                      win_valid,
    input  logic                      win_ready,
    output logic                      center_value,
    output logic [7:0]                neighbor_values,
    output logic [$clog2(WIDTH)-1:0]  win_x,
    output logic [$clog2(HEIGHT)-1:0] win_y,
    output logic                      win_last,
    output logic                      busy,
    output logic                      done
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);

    state_t                  r_state;
    logic [WIDTH*HEIGHT-1:0] r_snap;
    logic [XW-1:0]           r_x;
    logic [YW-1:0]           r_y;
    logic                    r_valid;
    logic                    r_busy;
    logic                    r_done;

    logic w_x_end;
    logic w_last;

    assign w_x_end = (r_x == XW'(WIDTH - 1));
    // Gated by valid so that x/y parked at the last cell after a scan do not
    // leave win_last asserted while idle.
    assign w_last  = r_valid && w_x_end && (r_y == YW'(HEIGHT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_snap  <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_snap  <= board_in;
                        r_x     <= '0;
                        r_y     <= '0;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
                    if (win_ready) begin
                        if (w_last) begin
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else if (w_x_end) begin
                            r_x <= '0;
                            r_y <= r_y + YW'(1);
                        end else begin
                            r_x <= r_x + XW'(1);
                        end
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    conway_cell_fetch #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_fetch (
        .i_snap      (r_snap),
        .i_x         (r_x),
        .i_y         (r_y),
        .o_center    (center_value),
        .o_neighbors (neighbor_values)
    );

    assign win_valid = r_valid;
    assign win_x     = r_x;
    assign win_y     = r_y;
    assign win_last  = w_last;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_conway_window_gen.sv
module tb_conway_window_gen;

    localparam int W = 4;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] board_in = '0;
    logic        win_valid;
    logic        win_ready = 1'b1;
    logic        center_value;
    logic [7:0]  neighbor_values;
    logic [1:0]  win_x;
    logic [1:0]  win_y;
    logic        win_last;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         x;
        int         y;
        logic       c;
        logic [7:0] nb;
        logic       last;
    } win_t;

    win_t exp_q[$];

    conway_window_gen #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .board_in        (board_in),
        .win_valid       (win_valid),
        .win_ready       (win_ready),
        .center_value    (center_value),
        .neighbor_values (neighbor_values),
        .win_x           (win_x),
        .win_y           (win_y),
        .win_last        (win_last),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Hand-computed expected {centre, neighbours} for the 4x4 test boards.
    // t=0 empty, t=1 single live cell (1,1), t=2 single live cell (3,3).
    function automatic logic [8:0] exp_win(input int t, input int x, input int y);
        int k;
        k = y * 4 + x;
        exp_win = 9'h000;
        if (t == 1) begin
            case (k)
                0:  exp_win = 9'h080;
                1:  exp_win = 9'h040;
                2:  exp_win = 9'h020;
                4:  exp_win = 9'h010;
                5:  exp_win = 9'h100;
                6:  exp_win = 9'h008;
                8:  exp_win = 9'h004;
                9:  exp_win = 9'h002;
                10: exp_win = 9'h001;
                default: exp_win = 9'h000;
            endcase
        end else if (t == 2) begin
`ifdef CONWAY_WRAP_EN
            case (k)
                10: exp_win = 9'h080;
                11: exp_win = 9'h040;
                8:  exp_win = 9'h020;
                14: exp_win = 9'h010;
                15: exp_win = 9'h100;
                12: exp_win = 9'h008;
                2:  exp_win = 9'h004;
                3:  exp_win = 9'h002;
                0:  exp_win = 9'h001;
                default: exp_win = 9'h000;
            endcase
`else
            case (k)
                10: exp_win = 9'h080;
                11: exp_win = 9'h040;
                14: exp_win = 9'h010;
                15: exp_win = 9'h100;
                default: exp_win = 9'h000;
            endcase
`endif
        end
    endfunction

    function automatic logic [15:0] board_of(input int t);
        case (t)
            1:       board_of = 16'h0020;
            2:       board_of = 16'h8000;
            default: board_of = 16'h0000;
        endcase
    endfunction

    // Monitor: every accepted window is checked against the head of the queue.
    initial begin
        win_t e;
        forever begin
            @(negedge clk);
            if (win_valid && win_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_window", {win_y, win_x}, 32'hffff_ffff);
                end else begin
                    e = exp_q.pop_front();
                    chk("win_x",  32'(win_x),           32'(e.x));
                    chk("win_y",  32'(win_y),           32'(e.y));
                    chk("center", 32'(center_value),    32'(e.c));
                    chk("nbrs",   32'(neighbor_values), 32'(e.nb));
                    chk("last",   32'(win_last),        32'(e.last));
                end
            end
        end
    end

    task automatic push_scan(input int t);
        win_t e;
        logic [8:0] v;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                v      = exp_win(t, x, y);
                e.x    = x;
                e.y    = y;
                e.c    = v[8];
                e.nb   = v[7:0];
                e.last = (x == W - 1) && (y == H - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic wait_at(input int x, input int y, output bit ok);
        int n = 0;
        ok = 0;
        while (!(win_valid && win_x == 2'(x) && win_y == 2'(y)) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        ok = (n < 100);
        if (!ok) chk("wait_window_timeout", 32'(n), 32'd0);
    endtask

    // mode 0 plain, 1 backpressure at (1,0), 2 start+board flip mid-scan,
    // 3 reset at (2,1).
    task automatic run_scan(input int t, input int mode);
        int n;
        bit ok;
        logic [8:0] v;
        push_scan(t);
        @(posedge clk); #1;
        board_in = board_of(t);
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        chk("valid_after_start", 32'(win_valid), 32'd1);
        chk("busy_after_start",  32'(busy),      32'd1);

        if (mode == 1) begin
            wait_at(1, 0, ok);
            win_ready = 1'b0;
            v = exp_win(t, 1, 0);
            for (int i = 0; i < 3; i++) begin
                @(posedge clk); #1;
                chk("bp_valid", 32'(win_valid),       32'd1);
                chk("bp_xy",    32'({win_y, win_x}),  32'h0001);
                chk("bp_nbrs",  32'(neighbor_values), 32'(v[7:0]));
                chk("bp_ctr",   32'(center_value),    32'(v[8]));
            end
            win_ready = 1'b1;
        end else if (mode == 2) begin
            wait_at(2, 0, ok);
            start    = 1'b1;
            board_in = ~board_in;
            @(posedge clk); #1;
            start    = 1'b0;
        end else if (mode == 3) begin
            wait_at(2, 1, ok);
            rst = 1'b1;
            #1;
            chk("rst_valid", 32'(win_valid), 32'd0);
            chk("rst_busy",  32'(busy),      32'd0);
            exp_q.delete();
            @(posedge clk); #1;
            rst = 1'b0;
            for (int i = 0; i < 5; i++) begin
                @(posedge clk); #1;
                chk("rst_no_done",  32'(done),      32'd0);
                chk("rst_no_valid", 32'(win_valid), 32'd0);
            end
            return;
        end

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("scan_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        chk("done_pulse",     32'(done),      32'd1);
        chk("done_valid_low", 32'(win_valid), 32'd0);
        chk("done_busy",      32'(busy),      32'd1);
        if (mode == 0 && t == 0) chk("scan_cycles", 32'(n), 32'(W * H));
        @(posedge clk); #1;
        chk("done_cleared", 32'(done), 32'd0);
        chk("idle_busy",    32'(busy), 32'd0);
        if (mode == 2) begin
            for (int i = 0; i < 3; i++) begin
                @(posedge clk); #1;
                chk("no_restart", 32'(win_valid), 32'd0);
            end
        end
    endtask

    initial begin
        #3;
        chk("rst_valid0", 32'(win_valid),       32'd0);
        chk("rst_last0",  32'(win_last),        32'd0);
        chk("rst_busy0",  32'(busy),            32'd0);
        chk("rst_done0",  32'(done),            32'd0);
        chk("rst_xy0",    32'({win_y, win_x}),  32'd0);
        chk("rst_ctr0",   32'(center_value),    32'd0);
        chk("rst_nb0",    32'(neighbor_values), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_valid", 32'(win_valid), 32'd0);

        run_scan(0, 0);
        run_scan(1, 0);
        run_scan(2, 0);
        run_scan(1, 1);
        run_scan(1, 2);
        run_scan(1, 3);
        run_scan(0, 0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/conway_window_gen.md
Name: conway_window_gen

Overview:
- Produces the input side of the per-cell rule logic: one centre bit plus its 8 neighbour bits, for every cell of a WIDTH x HEIGHT board.
- Latches a board snapshot on `start`, then scans it in raster order. Each scan step emits one 3x3 window over a valid/ready handshake.
- Downstream rule logic consumes each window and returns the next-generation bit to the board store.

Parameters:
- WIDTH, 16, board columns; minimum 3.
- HEIGHT, 16, board rows; minimum 3.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  begin a scan; sampled only in IDLE.
- board_in  input  WIDTH*HEIGHT  board state; cell (x,y) is bit y*WIDTH+x.
- win_valid  output  1  window on outputs is valid.
- win_ready  input  1  consumer accepts the window.
- center_value  output  1  cell (x,y).
- neighbor_values  output  8  neighbour bits; ordering defined in Behaviour.
- win_x  output  $clog2(WIDTH)  column of the current window.
- win_y  output  $clog2(HEIGHT)  row of the current window.
- win_last  output  1  current window is (WIDTH-1, HEIGHT-1).
- busy  output  1  high in SCAN and DONE.
- done  output  1  one-cycle pulse after the last window transfers.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; snapshot, x and y cleared.
  - win_valid=0, win_last=0, busy=0, done=0, win_x=0, win_y=0.
  - center_value=0, neighbor_values=0.
- FSM, 3 states:
  - IDLE: `start`=1 latches board_in into the snapshot register, sets x=y=0, moves to SCAN. win_valid rises the cycle after `start` is sampled.
  - SCAN: win_valid=1. On win_valid&win_ready:
    - if win_last, go to DONE;
    - else if x==WIDTH-1, set x=0 and y=y+1;
    - else x=x+1.
  - DONE: done=1 and win_valid=0 for exactly one cycle, then IDLE.
- Handshake:
  - While win_ready=0, win_valid stays high and win_x, win_y, center_value, neighbor_values and win_last hold stable.
  - Exactly one window transfers per cycle with valid&ready.
  - With win_ready tied high, a full scan takes WIDTH*HEIGHT cycles plus 1 cycle for DONE.
- Window outputs are a combinational function of the snapshot register and the x/y registers only, so they change only after a handshake or a start.
- neighbor_values ordering, by offset (dx,dy):
  - bit0=(-1,-1), bit1=(0,-1), bit2=(+1,-1)
  - bit3=(-1,0), bit4=(+1,0)
  - bit5=(-1,+1), bit6=(0,+1), bit7=(+1,+1)
- Edge handling: neighbour coordinates wrap modulo WIDTH/HEIGHT, or read as dead cells, per the optional feature.
- Counters wrap explicitly by compare. Never rely on power-of-2 overflow; WIDTH and HEIGHT need not be powers of 2.
- Boundary conditions:
  - `start` while busy: ignored.
  - board_in changes during a scan: no effect, because the snapshot is used.
  - `start` high on the cycle DONE returns to IDLE: sampled on the following cycle in IDLE.
  - rst mid-scan: immediate return to IDLE, win_valid=0. Any partial scan is abandoned and no `done` pulse is produced.

Optional Feature:
- Macro: CONWAY_WRAP_EN.
- Defined: toroidal board. A neighbour at x=-1 reads column WIDTH-1 and x=WIDTH reads column 0; rows behave the same way.
- Undefined: any neighbour outside the board reads 0 (dead border). The wrap mux logic is not generated.

Decomposition:
- Package conway_pkg:
  - state enum (IDLE, SCAN, DONE);
  - neighbour bit-index constants (NB_NW=0 through NB_SE=7);
  - helper function for the cell index y*WIDTH+x.
- One natural sub-module, conway_cell_fetch: combinational (x,y,snapshot) -> center_value/neighbor_values, including the edge handling.
- The FSM, counters and handshake stay in the top module.

Test Plan (WIDTH=HEIGHT=4, win_ready=1 unless stated):
- All-zero board, `start` pulse:
  - 16 windows, all with center_value=0 and neighbor_values=8'h00;
  - win_last only at (3,3);
  - done=1 exactly one cycle after the 16th transfer; busy=0 the cycle after that.
- Single live cell (1,1) = bit 5:
  - window (0,0): neighbor_values=8'h80;
  - window (1,1): center_value=1, neighbor_values=8'h00;
  - window (2,2): neighbor_values=8'h01;
  - window (1,0): neighbor_values=8'h40.
- Live cell (3,3) = bit 15:
  - window (0,0) gives neighbor_values=8'h01 with CONWAY_WRAP_EN defined;
  - it gives 8'h00 with the macro undefined.
- Backpressure: drop win_ready for 3 cycles at window (1,0) -> win_valid stays 1; win_x=1, win_y=0 and the data are unchanged; the next transfer is (2,0).
- Start while busy and board change:
  - pulse `start` and flip all of board_in mid-scan;
  - the scan is not restarted and the windows reflect the original snapshot.
- Reset mid-scan:
  - assert rst at window (2,1) -> win_valid=0 and busy=0 immediately, and no `done` pulse;
  - a new `start` begins again at (0,0).
